// File: rtl/fp_share_pkg.sv
// Shared constants and the truncated single-precision multiply used by the
// shared multiplier controller.
package fp_share_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned MAN_KEEP = 14;
  localparam int unsigned BIAS     = 127;
  localparam int unsigned PROD_W   = 2 * MAN_KEEP;

  // Reduced-precision multiply: top 13 fraction bits per operand, no rounding,
  // exponent wraps on overflow/underflow.
  function automatic logic [FP_W-1:0] fp_mul_trunc(input logic [FP_W-1:0] a,
                                                   input logic [FP_W-1:0] b,
                                                   input logic            zero_flush);
    logic                sign;
    logic [EXP_W-1:0]    ea;
    logic [EXP_W-1:0]    eb;
    logic [MAN_KEEP-1:0] ma;
    logic [MAN_KEEP-1:0] mb;
    logic [PROD_W-1:0]   p;
    logic [EXP_W:0]      exp9;
    logic [MAN_W-1:0]    man;
    sign = a[FP_W-1] ^ b[FP_W-1];
    ea   = a[FP_W-2 -: EXP_W];
    eb   = b[FP_W-2 -: EXP_W];
    ma   = {1'b1, a[MAN_W-1 -: MAN_KEEP-1]};
    mb   = {1'b1, b[MAN_W-1 -: MAN_KEEP-1]};
    p    = PROD_W'(ma) * PROD_W'(mb);
    if (p[PROD_W-1]) begin
      exp9 = {1'b0, ea} + {1'b0, eb} - (EXP_W+1)'(BIAS - 1);
      man  = p[PROD_W-2 -: MAN_W];
    end else begin
      exp9 = {1'b0, ea} + {1'b0, eb} - (EXP_W+1)'(BIAS);
      man  = p[PROD_W-3 -: MAN_W];
    end
    if (zero_flush && ((ea == '0) || (eb == '0))) begin
      return {sign, (FP_W-1)'(0)};
    end
    return {sign, exp9[EXP_W-1:0], man};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after rr_ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  input  logic            enable,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_share_ctrl.sv
// One truncated float multiplier shared by N_REQ requesters: round-robin
// grant, operand stage A, result stage B with backpressure.
module fp_mul_share_ctrl
  import fp_share_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_W       = 2,
  parameter bit          ZERO_FLUSH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [FP_W-1:0]       resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
);

  logic             a_valid;
  logic [FP_W-1:0]  a_op_a;
  logic [FP_W-1:0]  a_op_b;
  logic [ID_W-1:0]  a_id;
  logic [ID_W-1:0]  rr_ptr;

  logic             b_load_c;
  logic             a_adv_c;
  logic             a_load_c;
  logic             accept_c;
  logic [N_REQ-1:0] gnt_c;
  logic [ID_W-1:0]  gnt_id_c;
  logic [FP_W-1:0]  sel_a_c;
  logic [FP_W-1:0]  sel_b_c;

  assign b_load_c = ~resp_valid | resp_ready;
  assign a_adv_c  = a_valid & b_load_c;
  assign a_load_c = ~a_valid | a_adv_c;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .enable (a_load_c),
    .gnt    (gnt_c),
    .gnt_id (gnt_id_c)
  );

  assign req_ready = gnt_c;
  assign accept_c  = |gnt_c;
  assign busy      = a_valid | resp_valid;

  // One-hot operand select driven by the grant vector.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) begin
        sel_a_c = sel_a_c | req_a[i*FP_W +: FP_W];
        sel_b_c = sel_b_c | req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_op_a  <= '0;
      a_op_b  <= '0;
      a_id    <= '0;
      rr_ptr  <= '0;
    end else begin
      if (accept_c) begin
        a_valid <= 1'b1;
        a_op_a  <= sel_a_c;
        a_op_b  <= sel_b_c;
        a_id    <= gnt_id_c;
        rr_ptr  <= (gnt_id_c == ID_W'(N_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
      end else if (a_adv_c) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Result stage keeps data/id untouched when it empties or stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else if (b_load_c) begin
      resp_valid <= a_valid;
      if (a_valid) begin
        resp_data <= fp_mul_trunc(a_op_a, a_op_b, ZERO_FLUSH);
        resp_id   <= a_id;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_share_ctrl.sv
// Directed bench for fp_mul_share_ctrl with hand-computed products and grants.
module tb_fp_mul_share_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [W-1:0]    resp_id;
  logic            busy;

  int n_checks;
  int n_fail;

  // Per-requester operands for streaming tests: 2.0 * (i+1).
  logic [31:0] rr_b   [0:3];
  logic [31:0] rr_res [0:3];

  fp_mul_share_ctrl #(
    .N_REQ      (N),
    .ID_W       (W),
    .ZERO_FLUSH (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_stream_ops;
    rr_b[0] = 32'h3F800000; rr_res[0] = 32'h40000000;
    rr_b[1] = 32'h40000000; rr_res[1] = 32'h40800000;
    rr_b[2] = 32'h40400000; rr_res[2] = 32'h40C00000;
    rr_b[3] = 32'h40800000; rr_res[3] = 32'h41000000;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h40000000;
      req_b[32*i +: 32] = rr_b[i];
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #2;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: resp_valid=%b busy=%b, want 0 0", resp_valid, busy);
    end
    n_checks++;
    if (resp_data !== 32'h0 || resp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h id=%0d, want 0 0", resp_data, resp_id);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: resp_valid=%b busy=%b ready=%b, want 0 0 0000",
               resp_valid, busy, req_ready);
    end
  endtask

  task automatic test_arith;
    logic [31:0] va [0:4];
    logic [31:0] vb [0:4];
    logic [31:0] vr [0:4];
    logic [3:0]  exp_rdy;
    int          id;
    va[0] = 32'h40000000; vb[0] = 32'h40400000; vr[0] = 32'h40C00000;
    va[1] = 32'h3FC00000; vb[1] = 32'h3FC00000; vr[1] = 32'h40100000;
    va[2] = 32'hC0000000; vb[2] = 32'h40400000; vr[2] = 32'hC0C00000;
    va[3] = 32'h00000000; vb[3] = 32'h40400000; vr[3] = 32'h00000000;
    va[4] = 32'h80000000; vb[4] = 32'h40400000; vr[4] = 32'h80000000;
    for (int k = 0; k < 5; k++) begin
      id                 = k % 4;
      exp_rdy            = 4'(1) << id;
      resp_ready         = 1'b1;
      req_valid          = '0;
      req_valid[id]      = 1'b1;
      req_a[32*id +: 32] = va[k];
      req_b[32*id +: 32] = vb[k];
      #1;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL arith_grant[%0d]: ready=%b, want %b", k, req_ready, exp_rdy);
      end
      tick();
      req_valid = '0;
      #1;
      n_checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL arith_stageA[%0d]: resp_valid=%b busy=%b, want 0 1", k, resp_valid, busy);
      end
      tick();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== vr[k] || resp_id !== W'(id)) begin
        n_fail++;
        $display("FAIL arith_result[%0d]: valid=%b data=%h id=%0d, want 1 %h %0d",
                 k, resp_valid, resp_data, resp_id, vr[k], id);
      end
      tick();
      n_checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL arith_drain[%0d]: resp_valid=%b busy=%b, want 0 0", k, resp_valid, busy);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    int         eid;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    load_stream_ops();
    resp_ready = 1'b1;
    for (int w = 0; w < 10; w++) begin
      req_valid = (w < 8) ? 4'hF : 4'h0;
      #1;
      exp_rdy = (w < 8) ? (4'(1) << (w % 4)) : 4'b0000;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_grant[w%0d]: ready=%b, want %b", w, req_ready, exp_rdy);
      end
      if (w >= 2) begin
        eid = (w - 2) % 4;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== W'(eid) || resp_data !== rr_res[eid]) begin
          n_fail++;
          $display("FAIL rr_result[w%0d]: valid=%b id=%0d data=%h, want 1 %0d %h",
                   w, resp_valid, resp_id, resp_data, eid, rr_res[eid]);
        end
      end
      tick();
    end
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle: resp_valid=%b busy=%b, want 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_back_to_back_stall;
    logic [3:0] exp_rdy [0:10];
    int         exp_id  [0:10];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    exp_id  = '{-1, -1, 0, 0, 0, 0, 0, 1, 2, 3, -1};
    load_stream_ops();
    for (int w = 0; w < 11; w++) begin
      req_valid  = (w <= 7) ? 4'hF : 4'h0;
      resp_ready = (w >= 1 && w <= 5) ? 1'b0 : 1'b1;
      #1;
      n_checks++;
      if (req_ready !== exp_rdy[w]) begin
        n_fail++;
        $display("FAIL bp_grant[w%0d]: ready=%b, want %b", w, req_ready, exp_rdy[w]);
      end
      n_checks++;
      if (exp_id[w] < 0) begin
        if (resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_empty[w%0d]: resp_valid=%b, want 0", w, resp_valid);
        end
      end else if (resp_valid !== 1'b1 || resp_id !== W'(exp_id[w]) ||
                   resp_data !== rr_res[exp_id[w]]) begin
        n_fail++;
        $display("FAIL bp_result[w%0d]: valid=%b id=%0d data=%h, want 1 %0d %h",
                 w, resp_valid, resp_id, resp_data, exp_id[w], rr_res[exp_id[w]]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stream;
    load_stream_ops();
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_fill0: ready=%b, want 0001", req_ready);
    end
    tick();
    tick();
    n_checks++;
    if (resp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_full: valid=%b busy=%b ready=%b, want 1 1 0000",
               resp_valid, busy, req_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_async_reset: valid=%b busy=%b data=%h, want 0 0 0",
               resp_valid, busy, resp_data);
    end
    tick();
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_ptr_reset: ready=%b, want 0001", req_ready);
    end
    tick();
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_restart: ready=%b valid=%b, want 0010 0", req_ready, resp_valid);
    end
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== rr_res[0]) begin
      n_fail++;
      $display("FAIL mid_first_result: valid=%b id=%0d data=%h, want 1 0 %h",
               resp_valid, resp_id, resp_data, rr_res[0]);
    end
    repeat (3) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_arith();
    test_round_robin();
    test_back_to_back_stall();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_share_ctrl.md
Name: fp_mul_share_ctrl

Overview:
- Shares one single-precision float multiplier datapath among N_REQ requesters, e.g. the twiddle-multiply lanes of the radix-4 butterfly.
- Round-robin arbitration over valid/ready request channels.
- Two-stage pipeline: operand register, then result register.
- Response channel returns the product tagged with the requester index and supports backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of resp_id; must satisfy 2**ID_W >= N_REQ.
- ZERO_FLUSH, 1, if 1, an operand with exponent 0 forces a result of {sign,31'b0}.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  32*N_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same packing.
- req_ready  out  N_REQ  one-hot grant/accept, combinational.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  32  IEEE-754 single product (truncated format below).
- resp_id  out  ID_W  index of the requester that issued the operands.
- busy  out  1  either pipeline stage holds data.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: resp_valid=0, resp_data=0, resp_id=0, busy=0, stage-A valid=0, rr_ptr=0. Reset asserted mid-operation flushes both stages; in-flight results are lost.
- Stage advance rules:
  - B can load when B is empty or resp_ready=1.
  - A advances into B when A is valid and B can load.
  - A can load when A is empty or A advances.
- Arbitration:
  - When A can load, search from rr_ptr upward with wrap-around, mod N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - If A cannot load, req_ready=0.
  - rr_ptr becomes (i+1) mod N_REQ only on an accepted handshake; otherwise it holds.
- Requester rules: a requester holds valid and operands stable until ready. Deasserting without a handshake is legal but not recommended.
- Handshake:
  - Accept occurs at the edge where req_valid[i] & req_ready[i]. Stage A latches a, b and id.
  - resp_valid rises at the next edge, when A advances into B. Latency is 2 edges from request acceptance with no stall.
  - Throughput is 1 result per cycle.
- Backpressure:
  - With resp_valid=1 and resp_ready=0, resp_data and resp_id hold stable.
  - A holds its contents; at most one new request is accepted into an empty A. After that, req_ready=0 until the stall clears.
- Simultaneous events:
  - Response consumed and new result arriving in the same edge: B reloads and resp_valid stays 1.
  - New accept and A draining in the same edge: A reloads.
- busy = A_valid | resp_valid.
- Arithmetic (stage A→B, combinational, registered into B):
  - sign = a[31]^b[31].
  - ma = {1, a[22:10]}, mb = {1, b[22:10]}, both 14 bits. p = ma*mb, 28 bits unsigned.
  - If p[27]=1: exp = a[30:23]+b[30:23]-126 and man = p[26:4].
  - Else: exp = a[30:23]+b[30:23]-127 and man = p[25:3].
  - The exponent is computed in 9 bits and truncated to 8, so overflow/underflow wrap. NaN/Inf are not handled.
  - With ZERO_FLUSH=1, either exponent 0 gives resp_data = {sign, 31'b0}.

Decomposition:
- Package fp_share_pkg holds:
  - FP_W=32, EXP_W=8, MAN_W=23, MAN_KEEP=14, BIAS=127.
  - Function fp_mul_trunc(a, b, zero_flush) returning 32 bits.
- Sub-module rr_arbiter #(N), implemented as a separate module:
  - Inputs: req, rr_ptr, enable.
  - Outputs: one-hot gnt and encoded gnt_id.
  - Purely combinational; the rr_ptr register stays in the parent.
- The parent holds stage registers, handshake logic and the multiply.

Test Plan:
- Single request, requester 0: a=0x40000000 (2.0), b=0x40400000 (3.0), resp_ready=1 → resp_valid 2 edges after accept; resp_data=0x40C00000; resp_id=0.
- Normalize-carry path: a=b=0x3FC00000 (1.5) → resp_data=0x40100000 (2.25). Sign: a=0xC0000000, b=0x40400000 → 0xC0C00000.
- Zero flush: a=0x00000000, b=0x40400000 with ZERO_FLUSH=1 → 0x00000000; a=0x80000000 → 0x80000000.
- All 4 requesters valid continuously, resp_ready=1 → grants in order 0,1,2,3,0,1; one result per cycle; resp_id in the same order; no starvation.
- Backpressure: resp_ready=0 for 5 cycles while all requesters are valid → exactly one extra accept, then req_ready=0; resp_data/resp_id stable. On resp_ready=1, results drain in order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with both stages full → resp_valid and busy go 0 immediately. After release, first grant goes to requester 0 (rr_ptr=0).
